meter_countdown_sequencer: RTL
==============================

// Module: meter_countdown_sequencer
// PURPOSE
// - Sequences the parking-meter time datapath: accepts coin pulses on DSW1..DSW4, credits time,
//   counts it down once per second, drives status LED and expiry flag.
// - Sits between the board switches and the BCD display converter; time_left feeds BCD conversion.
// PARAMETERS
// - TICK_DIV    50_000_000  clk cycles per 1 s tick (>=2)
// - VAL1..VAL4  60/120/180/300  seconds credited per DSW1..DSW4 coin
// - MAX_TIME    9999        saturation ceiling, seconds (fits 14 bits)
// - WARN_TIME   120         at/below this (nonzero) -> WARN state
// - DEB_CYCLES  16          debounce stability window, cycles (used only with METER_DEBOUNCE_EN)
// PORTS
// - clk        in   1   system clock
// - reset      in   1   synchronous reset, active-high
// - DSW1..DSW4 in   1   coin switches, asynchronous, active-high level
// - time_left  out  14  remaining seconds, binary
// - LED        out  1   status lamp
// - expired    out  1   high in EXPIRED state
// - tick       out  1   one-cycle 1 s strobe
// - state_out  out  2   current FSM state encoding
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, time_left=0, LED=0, expired=0, tick=0, prescaler=0,
//   sync/edge flops=0; reset mid-countdown discards credited time.
// - Input path: each DSWn goes through a 2-flop synchroniser, then rising-edge detect -> coin_n pulse.
// - One coin credited per cycle; priority DSW1>DSW2>DSW3>DSW4; lower-priority simultaneous edges dropped.
// - Latency (no debounce): switch sampled high at edge k -> time_left updated at edge k+3.
// - Prescaler counts 0..TICK_DIV-1 only in RUN/WARN; tick=1 on count==TICK_DIV-1, then count wraps to 0.
//   Prescaler cleared to 0 on any transition out of IDLE/EXPIRED, so the first second is full length.
// - Arithmetic: next = min(time_left + coin_val, MAX_TIME) - (tick ? 1 : 0); 15-bit intermediate;
//   coin and tick in same cycle both apply; never below 0.
// - FSM (state_out): IDLE=00, RUN=01, WARN=10, EXPIRED=11; evaluated on next time value:
//   - IDLE: coin -> RUN if next>WARN_TIME else WARN; LED=0.
//   - RUN: next<=WARN_TIME -> WARN; LED=1 solid.
//   - WARN: next==0 -> EXPIRED; next>WARN_TIME (coin) -> RUN; LED toggles on every tick, set to 1 on entry.
//   - EXPIRED: expired=1, LED=1 solid, no countdown; coin -> RUN/WARN as from IDLE.
// - Coin at MAX_TIME: time_left stays MAX_TIME (minus tick if coincident); no wrap.
// - tick forced 0 outside RUN/WARN.
// CONFIGURATION
// - METER_DEBOUNCE_EN defined: each synchronised switch must hold a new level DEB_CYCLES
//   consecutive cycles before the filtered level changes; edge detect acts on filtered level;
//   latency becomes k+3+DEB_CYCLES; glitches shorter than DEB_CYCLES produce no coin.
// - Undefined: no filter; any synchronised rising edge is a coin; DEB_CYCLES ignored.
// STRUCTURE
// - Shared package meter_pkg: state encodings (IDLE/RUN/WARN/EXPIRED), default coin values,
//   MAX_TIME, time width constant (14).
// - Sub-module coin_input_conditioner (one per switch): synchroniser, optional debounce, edge pulse.
// - Top holds prescaler, time register, FSM and LED logic.
// TESTING (bench uses TICK_DIV=4, WARN_TIME=120, debounce off unless stated)
// - Reset then DSW1 pulse -> time_left=60 at edge k+3, state WARN, LED=1; after 4 clks 59.
// - DSW4 pulse from IDLE -> 300, RUN; count to 120 -> WARN, LED toggles each tick.
// - Countdown to 0 -> EXPIRED, expired=1, time_left holds 0, tick stays 0; DSW2 -> 120, WARN.
// - DSW1 and DSW3 rise same cycle at time 0 -> only +60 credited.
// - Preload 9990, DSW4 -> 9999; coin coincident with tick at 9999 -> 9998.
// - Reset asserted at time_left=200 -> next edge time_left=0, IDLE, LED=0; with
//   METER_DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle DSW1 glitch -> no credit, 20-cycle press -> +60.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter time datapath: FSM state
// encodings, default coin values, time width and a saturating adder.
package meter_pkg;

  localparam int unsigned TIME_W        = 14;
  localparam int unsigned SUM_W         = TIME_W + 1;

  localparam int unsigned VAL1_DEF      = 60;
  localparam int unsigned VAL2_DEF      = 120;
  localparam int unsigned VAL3_DEF      = 180;
  localparam int unsigned VAL4_DEF      = 300;
  localparam int unsigned MAX_TIME_DEF  = 9999;
  localparam int unsigned WARN_TIME_DEF = 120;

  typedef logic [TIME_W-1:0] secs_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    WARN    = 2'b10,
    EXPIRED = 2'b11
  } meter_state_e;

  // Adds a coin value to the remaining time, clamping at the ceiling.
  // The extra sum bit keeps a near-ceiling add from wrapping before the clamp.
  function automatic secs_t sat_add(input secs_t a, input secs_t b, input secs_t ceil_v);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, ceil_v}) begin
      return ceil_v;
    end
    return sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/meter_countdown_sequencer_if.sv
// Board-side signal bundle of the meter sequencer: coin switches in,
// time/status out. The master side is the board/stimulus, the slave side
// is the sequencer.
interface meter_countdown_sequencer_if;
  import meter_pkg::*;

  logic        DSW1;
  logic        DSW2;
  logic        DSW3;
  logic        DSW4;
  secs_t       time_left;
  logic        LED;
  logic        expired;
  logic        tick;
  logic [1:0]  state_out;

  modport master (
    output DSW1, DSW2, DSW3, DSW4,
    input  time_left, LED, expired, tick, state_out
  );

  modport slave (
    input  DSW1, DSW2, DSW3, DSW4,
    output time_left, LED, expired, tick, state_out
  );

endinterface

// File: rtl/coin_input_conditioner.sv
// Conditions one asynchronous coin switch: two-flop synchroniser, optional
// level filter (enabled by defining METER_DEBOUNCE_EN), and a registered
// one-cycle pulse on each rising edge of the (filtered) level.
module coin_input_conditioner
`ifdef METER_DEBOUNCE_EN
#(
  parameter int unsigned DEB_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic coin
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  // Two-flop synchroniser for the asynchronous switch level.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

`ifdef METER_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             filt;

  // Filtered level follows the synchronised level only after it has held a
  // new value for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (sync2 == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      filt       <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  // Registered rising-edge detect; registering the pulse keeps the coin path
  // off the synchroniser output and fixes the switch-to-credit latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_d <= 1'b0;
      coin    <= 1'b0;
    end else begin
      level_d <= level;
      coin    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/meter_countdown_sequencer.sv
// Parking-meter time sequencer: credits coin time from four switches,
// counts it down once per second and drives the status lamp and expiry
// flag. Defining METER_DEBOUNCE_EN adds a DEB_CYCLES level filter on every
// coin switch.
module meter_countdown_sequencer
  import meter_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned VAL1       = VAL1_DEF,
  parameter int unsigned VAL2       = VAL2_DEF,
  parameter int unsigned VAL3       = VAL3_DEF,
  parameter int unsigned VAL4       = VAL4_DEF,
  parameter int unsigned MAX_TIME   = MAX_TIME_DEF,
  parameter int unsigned WARN_TIME  = WARN_TIME_DEF
`ifdef METER_DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 16
`endif
) (
  input logic                        clk,
  input logic                        reset,
  meter_countdown_sequencer_if.slave bus
);

  localparam int unsigned    PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam secs_t          MAX_V    = secs_t'(MAX_TIME);
  localparam secs_t          WARN_V   = secs_t'(WARN_TIME);

  logic [3:0]       sw;
  logic [3:0]       coin;
  secs_t            coin_val;
  logic             coin_any;

  meter_state_e     state;
  meter_state_e     next_state;
  secs_t            time_left;
  secs_t            next_time;
  secs_t            credited;
  logic             led_q;
  logic             led_next;
  logic [PRE_W-1:0] pre_cnt;
  logic             running;
  logic             tick;

  assign sw = {bus.DSW4, bus.DSW3, bus.DSW2, bus.DSW1};

  for (genvar i = 0; i < 4; i++) begin : g_cond
    coin_input_conditioner
`ifdef METER_DEBOUNCE_EN
      #(.DEB_CYCLES(DEB_CYCLES))
`endif
      u_cond (
        .clk   (clk),
        .reset (reset),
        .sw    (sw[i]),
        .coin  (coin[i])
      );
  end

  // Pick one coin per cycle, DSW1 highest; simultaneous lower coins are lost.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    coin_val = '0;
    if (coin[0]) begin
      coin_val = secs_t'(VAL1);
    end else if (coin[1]) begin
      coin_val = secs_t'(VAL2);
    end else if (coin[2]) begin
      coin_val = secs_t'(VAL3);
    end else if (coin[3]) begin
      coin_val = secs_t'(VAL4);
    end
  end

  assign coin_any = |coin;
  assign running  = (state == RUN) || (state == WARN);
  assign tick     = running && (pre_cnt == PRE_LAST);

  // Next time value: saturating credit, then the one-second decrement. The
  // zero guard is defensive; RUN/WARN never hold zero time.
  always_comb begin
    credited  = sat_add(time_left, coin_val, MAX_V);
    next_time = credited;
    if (tick && (credited != '0)) begin
      next_time = credited - 1'b1;
    end
  end

  // State and lamp decisions, all judged on the upcoming time value.
  always_comb begin
    next_state = state;
    led_next   = led_q;
    case (state)
      IDLE, EXPIRED: begin
        if (coin_any) begin
          next_state = (next_time > WARN_V) ? RUN : WARN;
        end
      end
      RUN: begin
        if (next_time == '0) begin
          next_state = EXPIRED;
        end else if (next_time <= WARN_V) begin
          next_state = WARN;
        end
      end
      WARN: begin
        if (next_time == '0) begin
          next_state = EXPIRED;
        end else if (next_time > WARN_V) begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase

    case (next_state)
      IDLE:    led_next = 1'b0;
      RUN:     led_next = 1'b1;
      EXPIRED: led_next = 1'b1;
      WARN: begin
        if (state != WARN) begin
          led_next = 1'b1;
        end else if (tick) begin
          led_next = ~led_q;
        end
      end
      default: led_next = 1'b0;
    endcase
  end

  // State, remaining time and lamp registers; reset discards all credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      time_left <= '0;
      led_q     <= 1'b0;
    end else begin
      state     <= next_state;
      time_left <= next_time;
      led_q     <= led_next;
    end
  end

  // One-second prescaler: idles at zero outside RUN/WARN, so leaving
  // IDLE/EXPIRED always starts a full-length first second.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (!running || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign bus.time_left = time_left;
  assign bus.LED       = led_q;
  assign bus.expired   = (state == EXPIRED);
  assign bus.tick      = tick;
  assign bus.state_out = state;

endmodule
